// File: rtl/noise_floor_ctrl_pkg.sv
// Shared tracking-engine definitions: controller state encoding, the
// estimator's reset floor, and the m-sequence period helper.
package noise_floor_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_TRACK  = 2'd2
    } ctrl_state_e;

    localparam logic [15:0] NF_RESET_FLOOR = 16'd784;

    // Number of chips in one m-sequence period for an LFSR of the given length.
    function automatic int unsigned code_period(input int unsigned code_length);
        return (32'd1 << code_length) - 32'd1;
    endfunction

endpackage

// File: rtl/noise_floor_ctrl_if.sv
// Bus between the noise-floor sequencer (master) and the noise-floor
// estimator (slave): sample/chip strobes, smoothing code, floor load and
// the estimator's current floor.
interface noise_floor_ctrl_if;
    logic        data_down_en;
    logic        shift_code;
    logic [1:0]  smooth_factor;
    logic        set_noise_floor;
    logic [15:0] noise_floor_i;
    logic [15:0] nf_value;

    modport master (
        output data_down_en,
        output shift_code,
        output smooth_factor,
        output set_noise_floor,
        output noise_floor_i,
        input  nf_value
    );

    modport slave (
        input  data_down_en,
        input  shift_code,
        input  smooth_factor,
        input  set_noise_floor,
        input  noise_floor_i,
        output nf_value
    );
endinterface

// File: rtl/noise_floor_ctrl_chip_strobe_gen.sv
// Samples-per-chip divider and chip counter. Both run in every controller
// state and are cleared only by rst_b so they stay aligned with the
// estimator's LFSR, which is likewise reset only by rst_b.
module chip_strobe_gen
    import noise_floor_ctrl_pkg::*;
#(
    parameter int CODE_LENGTH = 10,
    parameter int DIV_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                sample_valid,
    input  logic [DIV_BITS-1:0] cfg_code_div,
    output logic                shift_code,
    output logic                period_wrap
);

    localparam logic [CODE_LENGTH-1:0] LAST_CHIP =
        CODE_LENGTH'(code_period(CODE_LENGTH) - 32'd1);

    logic [DIV_BITS-1:0]    div_cnt_r;
    logic [CODE_LENGTH-1:0] chip_cnt_r;

    // The chip strobe must reach the estimator in the same cycle as the sample.
    assign shift_code  = sample_valid && (div_cnt_r == cfg_code_div);
    assign period_wrap = shift_code && (chip_cnt_r == LAST_CHIP);

    // Divide valid samples down to chips.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            div_cnt_r <= {DIV_BITS{1'b0}};
        end else if (sample_valid) begin
            if (div_cnt_r == cfg_code_div) begin
                div_cnt_r <= {DIV_BITS{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + {{(DIV_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    // Count chips modulo the m-sequence period.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            chip_cnt_r <= {CODE_LENGTH{1'b0}};
        end else if (shift_code) begin
            if (chip_cnt_r == LAST_CHIP) begin
                chip_cnt_r <= {CODE_LENGTH{1'b0}};
            end else begin
                chip_cnt_r <= chip_cnt_r + {{(CODE_LENGTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/noise_floor_ctrl.sv
// Noise-floor estimator sequencer: chip strobe and sample gating, smoothing
// schedule (fast warm-up, slow tracking), initial/software floor loads and
// update reporting with a latched copy of the new floor.
module noise_floor_ctrl
    import noise_floor_ctrl_pkg::*;
#(
    parameter int CODE_LENGTH = 10,
    parameter int DIV_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                sample_valid,
    input  logic                cfg_enable,
    input  logic [DIV_BITS-1:0] cfg_code_div,
    input  logic [15:0]         cfg_init_floor,
    input  logic [3:0]          cfg_fast_updates,
    input  logic [1:0]          cfg_fast_factor,
    input  logic [1:0]          cfg_slow_factor,
    input  logic                sw_set,
    input  logic [15:0]         sw_floor,
    noise_floor_ctrl_if.master  est,
    output logic                nf_update,
    output logic [15:0]         nf_latched,
    output logic [1:0]          ctrl_state
);

    logic        shift_code_s;
    logic        period_wrap_s;
    logic [1:0]  smooth_s;
    logic [3:0]  upd_inc_s;
    logic        warmup_done_s;

    ctrl_state_e state_r;
    logic [3:0]  upd_cnt_r;
    logic        discard_r;
    logic [2:0]  pipe_r;          // nf_update_r acts as the fourth (done) stage
    logic        set_nf_r;
    logic [15:0] nf_i_r;
    logic        nf_update_r;
    logic [15:0] nf_latched_r;

    chip_strobe_gen #(
        .CODE_LENGTH (CODE_LENGTH),
        .DIV_BITS    (DIV_BITS)
    ) u_chip_strobe_gen (
        .clk          (clk),
        .rst_b        (rst_b),
        .sample_valid (sample_valid),
        .cfg_code_div (cfg_code_div),
        .shift_code   (shift_code_s),
        .period_wrap  (period_wrap_s)
    );

    // Smoothing code follows the current state: fast only while warming up.
    always_comb begin
        smooth_s = cfg_slow_factor;
        case (state_r)
            ST_WARMUP: smooth_s = cfg_fast_factor;
            ST_TRACK:  smooth_s = cfg_slow_factor;
            default:   smooth_s = cfg_slow_factor;
        endcase
    end

    // Saturating update count and the warm-up exit test for the next update.
    always_comb begin
        upd_inc_s     = (upd_cnt_r == 4'hF) ? upd_cnt_r : (upd_cnt_r + 4'd1);
        warmup_done_s = (cfg_fast_updates == 4'd0) || (upd_inc_s == cfg_fast_updates);
    end

    assign est.data_down_en    = sample_valid & (state_r != ST_IDLE);
    assign est.shift_code      = shift_code_s;
    assign est.smooth_factor   = smooth_s;
    assign est.set_noise_floor = set_nf_r;
    assign est.noise_floor_i   = nf_i_r;
    assign nf_update           = nf_update_r;
    assign nf_latched          = nf_latched_r;
    assign ctrl_state          = state_r;

    // Sequencer FSM with floor loads, update pipe and floor latch. Priority:
    // disable, then enable from IDLE, then software set, then update handling.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r      <= ST_IDLE;
            upd_cnt_r    <= 4'd0;
            discard_r    <= 1'b0;
            pipe_r       <= 3'b000;
            set_nf_r     <= 1'b0;
            nf_i_r       <= NF_RESET_FLOOR;
            nf_update_r  <= 1'b0;
            nf_latched_r <= NF_RESET_FLOOR;
        end else begin
            set_nf_r    <= 1'b0;
            nf_update_r <= 1'b0;
            pipe_r      <= {pipe_r[1:0], period_wrap_s && (state_r != ST_IDLE)};

            if (!cfg_enable) begin
                state_r <= ST_IDLE;
                pipe_r  <= 3'b000;
            end else if (state_r == ST_IDLE) begin
                set_nf_r  <= 1'b1;
                nf_i_r    <= cfg_init_floor;
                upd_cnt_r <= 4'd0;
                discard_r <= 1'b1;
                state_r   <= ST_WARMUP;
                pipe_r    <= 3'b000;
            end else if (sw_set) begin
                set_nf_r  <= 1'b1;
                nf_i_r    <= sw_floor;
                upd_cnt_r <= 4'd0;
                discard_r <= 1'b1;
                state_r   <= ST_WARMUP;
                pipe_r    <= 3'b000;
            end else begin
                // The first period after a load is partial, so its update is dropped.
                if (pipe_r[2]) begin
                    if (discard_r) begin
                        discard_r <= 1'b0;
                    end else begin
                        nf_update_r  <= 1'b1;
                        nf_latched_r <= est.nf_value;
                    end
                end
                // Count the update the cycle it is reported; smoothing changes after.
                if (nf_update_r) begin
                    upd_cnt_r <= upd_inc_s;
                    if ((state_r == ST_WARMUP) && warmup_done_s) begin
                        state_r <= ST_TRACK;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_noise_floor_ctrl.sv
// Directed scoreboard bench for noise_floor_ctrl. With cfg_code_div = 1 and
// continuous samples from reset release, chips fall on odd cycles and the
// period (1023 chips) wraps at cycle 2045 + 2046*n; updates follow 4 cycles later.
module tb_noise_floor_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        sample_valid;
    logic        cfg_enable;
    logic [7:0]  cfg_code_div;
    logic [15:0] cfg_init_floor;
    logic [3:0]  cfg_fast_updates;
    logic [1:0]  cfg_fast_factor;
    logic [1:0]  cfg_slow_factor;
    logic        sw_set;
    logic [15:0] sw_floor;
    logic        nf_update;
    logic [15:0] nf_latched;
    logic [1:0]  ctrl_state;

    noise_floor_ctrl_if nf_bus ();

    noise_floor_ctrl #(.CODE_LENGTH(10), .DIV_BITS(8)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .sample_valid     (sample_valid),
        .cfg_enable       (cfg_enable),
        .cfg_code_div     (cfg_code_div),
        .cfg_init_floor   (cfg_init_floor),
        .cfg_fast_updates (cfg_fast_updates),
        .cfg_fast_factor  (cfg_fast_factor),
        .cfg_slow_factor  (cfg_slow_factor),
        .sw_set           (sw_set),
        .sw_floor         (sw_floor),
        .est              (nf_bus),
        .nf_update        (nf_update),
        .nf_latched       (nf_latched),
        .ctrl_state       (ctrl_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] floor;
        logic [1:0]  smooth;
        logic [1:0]  state;
    } upd_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } set_exp_t;

    upd_exp_t upd_q[$];
    set_exp_t set_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    // Cycle index since reset release.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_update(input int wrap, input logic [15:0] val,
                                 input logic [1:0] sm, input logic [1:0] st);
        upd_exp_t e;
        goto(wrap - 20);
        nf_bus.nf_value = val;
        e.cyc = wrap + 4; e.floor = val; e.smooth = sm; e.state = st;
        upd_q.push_back(e);
    endtask

    task automatic expect_set(input int c, input logic [15:0] v);
        set_exp_t s;
        s.cyc = c; s.val = v;
        set_q.push_back(s);
    endtask

    // Monitor: pop and compare whenever the DUT reports an update or a floor load.
    always @(negedge clk) begin
        upd_exp_t e;
        set_exp_t s;
        if (rst_b) begin
            if (nf_update) begin
                if (upd_q.size() == 0) begin
                    chk("unexpected_nf_update", cyc, -1);
                end else begin
                    e = upd_q.pop_front();
                    chk("update_cycle", cyc, e.cyc);
                    chk("nf_latched", nf_latched, e.floor);
                    chk("smooth_at_update", nf_bus.smooth_factor, e.smooth);
                    chk("state_at_update", ctrl_state, e.state);
                end
            end
            if (nf_bus.set_noise_floor) begin
                if (set_q.size() == 0) begin
                    chk("unexpected_set_noise_floor", cyc, -1);
                end else begin
                    s = set_q.pop_front();
                    chk("set_cycle", cyc, s.cyc);
                    chk("noise_floor_i", nf_bus.noise_floor_i, s.val);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        rst_b            = 1'b0;
        sample_valid     = 1'b1;
        cfg_enable       = 1'b0;
        cfg_code_div     = 8'd1;
        cfg_init_floor   = 16'd500;
        cfg_fast_updates = 4'd3;
        cfg_fast_factor  = 2'd0;
        cfg_slow_factor  = 2'd3;
        sw_set           = 1'b0;
        sw_floor         = 16'd900;
        nf_bus.nf_value  = 16'd0;

        repeat (3) @(negedge clk);
        chk("rst_state", ctrl_state, 0);
        chk("rst_noise_floor_i", nf_bus.noise_floor_i, 784);
        chk("rst_nf_latched", nf_latched, 784);
        chk("rst_set_noise_floor", nf_bus.set_noise_floor, 0);
        chk("rst_nf_update", nf_update, 0);
        chk("rst_shift_code", nf_bus.shift_code, 0);
        chk("rst_data_down_en", nf_bus.data_down_en, 0);
        chk("rst_smooth", nf_bus.smooth_factor, 3);
        rst_b = 1'b1;

        // Disabled: chip strobe on every second sample, no gated samples.
        for (int c = 1; c <= 6; c++) begin
            goto(c);
            @(negedge clk);
            chk("shift_code_pattern", nf_bus.shift_code, c % 2);
        end
        goto(50);
        @(negedge clk);
        chk("idle_data_down_en", nf_bus.data_down_en, 0);
        chk("idle_nf_latched", nf_latched, 784);
        chk("idle_state", ctrl_state, 0);

        // Enable with init floor 500, three fast updates.
        goto(100);
        expect_set(101, 16'd500);
        cfg_enable = 1'b1;
        goto(200);
        @(negedge clk);
        chk("warmup_state", ctrl_state, 1);
        chk("warmup_data_down_en", nf_bus.data_down_en, 1);
        chk("warmup_smooth", nf_bus.smooth_factor, 0);

        goto(2025);
        nf_bus.nf_value = 16'hDEAD;                  // first wrap, discarded
        expect_update(4091,  16'h1111, 2'd0, 2'd1);
        expect_update(6137,  16'h2222, 2'd0, 2'd1);
        expect_update(8183,  16'h3333, 2'd0, 2'd1);
        goto(8190);
        @(negedge clk);
        chk("track_state", ctrl_state, 2);
        chk("track_smooth", nf_bus.smooth_factor, 3);
        expect_update(10229, 16'h4444, 2'd3, 2'd2);

        // Software set two cycles after a wrap: that update is dropped.
        goto(12255);
        nf_bus.nf_value = 16'h5555;
        goto(12277);
        expect_set(12278, 16'd900);
        sw_set = 1'b1;
        goto(12278);
        sw_set = 1'b0;
        goto(12280);
        @(negedge clk);
        chk("swset_state", ctrl_state, 1);
        chk("swset_smooth", nf_bus.smooth_factor, 0);
        goto(14301);
        nf_bus.nf_value = 16'h6666;                  // partial period, discarded
        expect_update(16367, 16'h7777, 2'd0, 2'd1);

        // Disable mid-period, re-enable 50 cycles later with no warm-up.
        goto(17000);
        cfg_enable = 1'b0;
        goto(17010);
        @(negedge clk);
        chk("disabled_state", ctrl_state, 0);
        chk("disabled_data_down_en", nf_bus.data_down_en, 0);
        chk("disabled_smooth", nf_bus.smooth_factor, 3);
        goto(17050);
        cfg_init_floor   = 16'd600;
        cfg_fast_updates = 4'd0;
        expect_set(17051, 16'd600);
        cfg_enable = 1'b1;
        goto(18393);
        nf_bus.nf_value = 16'h8888;                  // first wrap after enable, discarded
        expect_update(20459, 16'h9999, 2'd0, 2'd1);
        goto(20466);
        @(negedge clk);
        chk("fast0_state", ctrl_state, 2);
        chk("fast0_smooth", nf_bus.smooth_factor, 3);
        expect_update(22505, 16'hAAAA, 2'd3, 2'd2);

        goto(22600);
        for (int c = 22601; c <= 22604; c++) begin
            goto(c);
            @(negedge clk);
            chk("late_shift_code_pattern", nf_bus.shift_code, c % 2);
        end
        chk("pending_updates", upd_q.size(), 0);
        chk("pending_sets", set_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
